// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes,
// FSM states and the default iteration count.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int ITER_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. o_hi_part/o_lo_part are product halves or rem/quot.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_mag_a,
   input  logic [WIDTH-1:0] i_mag_b,
   output logic [WIDTH-1:0] o_hi_part,
   output logic [WIDTH-1:0] o_lo_part
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH:0]   w_add_a;
   logic [WIDTH:0]   w_add_b;
   logic             w_carry;
   logic [WIDTH+1:0] w_sum;
   logic             w_take;

   // Shared adder: divide adds the inverted divisor, so bit WIDTH+1 is "no borrow".
   always_comb begin
      if (i_is_div) begin
         w_add_a = {r_acc, r_sr[WIDTH-1]};
         w_add_b = ~{1'b0, r_opnd};
         w_carry = 1'b1;
      end else begin
         w_add_a = {1'b0, r_acc};
         w_add_b = r_sr[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}};
         w_carry = 1'b0;
      end
      w_sum  = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(WIDTH+1){1'b0}}, w_carry};
      w_take = w_sum[WIDTH+1];
   end

   // Load magnitudes on accept, then advance one step per CALC cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_acc  <= '0;
         r_sr   <= '0;
         r_opnd <= '0;
      end else if (i_load) begin
         r_acc  <= '0;
         r_sr   <= i_mag_a;
         r_opnd <= i_mag_b;
      end else if (i_step) begin
         if (i_is_div) begin
            r_acc <= w_take ? w_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0];
            r_sr  <= {r_sr[WIDTH-2:0], w_take};
         end else begin
            r_acc <= w_sum[WIDTH:1];
            r_sr  <= {w_sum[0], r_sr[WIDTH-1:1]};
         end
      end else begin
         r_acc <= r_acc;
      end
   end

   assign o_hi_part = r_acc;
   assign o_lo_part = r_sr;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with FSM, sign fix-up and hi/lo registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, skipping CALC.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = ITER_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;

   logic               w_accept;
   logic               w_signed_in;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH-1:0]   w_step_hi;
   logic [WIDTH-1:0]   w_step_lo;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [2*WIDTH-1:0] w_prod_mag;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;
   state_t             w_start_state;

   assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_signed_in = (op == OP_MULT) || (op == OP_DIV);
   assign w_mag_a     = (w_signed_in && a[WIDTH-1]) ? -a : a;
   assign w_mag_b     = (w_signed_in && b[WIDTH-1]) ? -b : b;
   assign w_a_neg     = !r_op[0] && r_a[WIDTH-1];
   assign w_b_neg     = !r_op[0] && r_b[WIDTH-1];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_accept && !cancel),
      .i_step    (r_state == ST_CALC),
      .i_is_div  (r_op[1]),
      .i_mag_a   (w_mag_a),
      .i_mag_b   (w_mag_b),
      .o_hi_part (w_step_hi),
      .o_lo_part (w_step_lo)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic [WIDTH-1:0] w_ra_mag;
   logic [WIDTH-1:0] w_rb_mag;
   assign w_ra_mag   = w_a_neg ? -r_a : r_a;
   assign w_rb_mag   = w_b_neg ? -r_b : r_b;
   assign w_prod_mag = {{WIDTH{1'b0}}, w_ra_mag} * {{WIDTH{1'b0}}, w_rb_mag};
`else
   assign w_prod_mag = {w_step_hi, w_step_lo};
`endif

   // Where an accepted op goes first: multiplies skip CALC in the fast build.
   always_comb begin
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) begin
         w_start_state = ST_FIXUP;
      end else begin
         w_start_state = ST_CALC;
      end
`else
      w_start_state = ST_CALC;
`endif
   end

   // Sign fix-up of the magnitude results; divide by zero overrides to '1 / a.
   always_comb begin
      w_prod = (w_a_neg ^ w_b_neg) ? -w_prod_mag : w_prod_mag;
      if (r_op[1]) begin
         if (r_b == {WIDTH{1'b0}}) begin
            w_res_lo = {WIDTH{1'b1}};
            w_res_hi = r_a;
         end else begin
            w_res_lo = (w_a_neg ^ w_b_neg) ? -w_step_lo : w_step_lo;
            w_res_hi = w_a_neg ? -w_step_hi : w_step_hi;
         end
      end else begin
         w_res_hi = w_prod[2*WIDTH-1:WIDTH];
         w_res_lo = w_prod[WIDTH-1:0];
      end
   end

   // Control FSM with registered busy/done; reset beats cancel beats start.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_op    <= OP_MULT;
         r_a     <= '0;
         r_b     <= '0;
      end else if (cancel) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               r_cnt  <= '0;
               if (start) begin
                  r_state <= w_start_state;
                  r_busy  <= 1'b1;
                  r_op    <= op;
                  r_a     <= a;
                  r_b     <= b;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_CALC: begin
               if (r_cnt == CW'(ITER - 1)) begin
                  r_state <= ST_FIXUP;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            ST_FIXUP: begin
               r_hi    <= w_res_hi;
               r_lo    <= w_res_lo;
               r_state <= ST_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (honours MULDIV_FAST_MUL_EN for multiply latency).
module tb_muldiv_seq;

   localparam int DIV_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_seq dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Waits for done starting in cycle c0 after accept; returns cycle of done and busy count.
   task automatic wait_done(input int c0, output int cyc, output int busy_cnt);
      cyc = c0;
      busy_cnt = c0 - 1;
      while (done !== 1'b1 && cyc < 60) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         cyc++;
      end
   endtask

   task automatic accept(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      a = 32'hDEADBEEF; b = 32'h0BADF00D; op = ~o;
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el, input int lat, input string tag);
      int cyc, bc;
      accept(o, x, y);
      wait_done(1, cyc, bc);
      chk(32'(cyc), 32'(lat), {tag, "_lat"});
      chk(32'(bc), 32'(lat - 1), {tag, "_busy_cycles"});
      chk({31'd0, busy}, 32'd0, {tag, "_busy_at_done"});
      chk(hi, eh, {tag, "_hi"});
      chk(lo, el, {tag, "_lo"});
      tick();
      chk({31'd0, done}, 32'd0, {tag, "_done_one_cycle"});
   endtask

   initial begin
      int cyc, bc, dcnt;
      reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
      repeat (3) tick();
      chk({31'd0, busy}, 32'd0, "rst_busy");
      chk({31'd0, done}, 32'd0, "rst_done");
      chk(hi, 32'd0, "rst_hi");
      chk(lo, 32'd0, "rst_lo");
      reset = 1'b1;
      tick();

      run(2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MUL_LAT, "multu_max_x2");
      run(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT, "mult_neg3_x5");
      run(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, "div_neg7_2");
      run(2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, DIV_LAT, "divu_by0");
      run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT, "div_ovf");
      run(2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, DIV_LAT, "div_100_neg7");
      run(2'b11, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, DIV_LAT, "divu_big");
      run(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, DIV_LAT, "div_neg_by0");

      // Prior MULT result hi=1 lo=2, then a DIV cancelled in CALC cycle 10.
      run(2'b00, 32'd6, 32'h2AAAAAAB, 32'd1, 32'd2, MUL_LAT, "mult_pre_cancel");
      accept(2'b10, 32'd100, 32'd7);
      repeat (5) tick();
      chk({31'd0, busy}, 32'd1, "calc_busy");
      chk(hi, 32'd1, "calc_hi_hold");
      chk(lo, 32'd2, "calc_lo_hold");
      repeat (5) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk({31'd0, busy}, 32'd0, "cancel_busy");
      chk({31'd0, done}, 32'd0, "cancel_done");
      chk(hi, 32'd1, "cancel_hi");
      chk(lo, 32'd2, "cancel_lo");
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) dcnt++;
      end
      chk(32'(dcnt), 32'd0, "cancel_no_done");

      // Start raised mid-CALC must be ignored.
      accept(2'b11, 32'd100, 32'd7);
      repeat (4) tick();
      op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(6, cyc, bc);
      chk(32'(cyc), 32'd34, "ignore_start_lat");
      chk(hi, 32'd2, "ignore_start_hi");
      chk(lo, 32'd14, "ignore_start_lo");

      // Back-to-back: start held in the DONE cycle.
      tick();
      accept(2'b11, 32'd35, 32'd5);
      wait_done(1, cyc, bc);
      chk(lo, 32'd7, "b2b_first_lo");
      op = 2'b11; a = 32'd1000; b = 32'd10; start = 1'b1;
      tick();
      start = 1'b0;
      chk({31'd0, busy}, 32'd1, "b2b_no_idle");
      chk({31'd0, done}, 32'd0, "b2b_done_drop");
      wait_done(1, cyc, bc);
      chk(32'(cyc), 32'd34, "b2b_second_lat");
      chk(hi, 32'd0, "b2b_hi");
      chk(lo, 32'd100, "b2b_lo");
      tick();

      // Cancel wins over a simultaneous start.
      op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
      tick();
      start = 1'b0; cancel = 1'b0;
      chk({31'd0, busy}, 32'd0, "cancel_vs_start_busy");
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) dcnt++;
      end
      chk(32'(dcnt), 32'd0, "cancel_vs_start_no_done");

      // Reset mid-operation discards it and clears results.
      accept(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (10) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk({31'd0, busy}, 32'd0, "midrst_busy");
      chk(hi, 32'd0, "midrst_hi");
      chk(lo, 32'd0, "midrst_lo");
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) dcnt++;
      end
      chk(32'(dcnt), 32'd0, "midrst_no_done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL provide parameter ITER, default 32, number of iterative cycles per operation; ITER SHALL equal WIDTH.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL provide port start, input, 1, request to begin an operation.
REQ-006 SHALL provide port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL provide ports a and b, input, WIDTH each, operands (rs, rt); b is the divisor.
REQ-008 SHALL provide port cancel, input, 1, abort of any in-flight operation (exception flush).
REQ-009 SHALL provide port busy, output, 1, operation in progress; the pipeline stalls on it.
REQ-010 SHALL provide port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL provide ports hi and lo, output, WIDTH each, registered results.

Function
REQ-012 SHALL implement states IDLE, CALC, FIXUP, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; it SHALL latch op, a and b on that edge and enter CALC.
REQ-014 SHALL ignore start while in CALC or FIXUP.
REQ-015 SHALL in CALC perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, for exactly ITER cycles, counted by a counter that runs 0..ITER-1.
REQ-016 SHALL go from CALC to FIXUP when the counter reaches ITER-1, and from FIXUP to DONE unconditionally.
REQ-017 SHALL in FIXUP apply sign correction for MULT and DIV and write hi/lo: for multiply, hi and lo hold the upper and lower halves of the 2*WIDTH product; for divide, lo holds the quotient and hi the remainder.
REQ-018 SHALL for DIV give the remainder the sign of a and negate the quotient when the signs of a and b differ.
REQ-019 SHALL for divide with b==0, for both DIV and DIVU, produce lo=all ones and hi=a, and still take full latency.
REQ-020 SHALL for DIV of 0x80000000 by 0xFFFFFFFF produce lo=0x80000000 and hi=0, with no error indication.
REQ-021 SHALL, when start is accepted on edge N, assert busy in cycles N+1..N+33 and assert done in cycle N+34 only.
REQ-022 SHALL return from DONE to IDLE on the next edge unless start is high, in which case it SHALL go directly to CALC, giving back-to-back operation.
REQ-023 SHALL keep hi and lo unchanged except on the FIXUP edge, including while idle and during CALC.
REQ-024 SHALL on cancel in any state go to IDLE on the next edge, drop busy and done, and leave hi and lo unchanged.
REQ-025 SHALL give cancel priority over a simultaneous start, which is then dropped.

Reset
REQ-026 SHALL, when reset is low at a rising edge, set state to IDLE, the counter to 0, busy to 0, done to 0, hi to 0 and lo to 0.
REQ-027 SHALL give reset priority over cancel and start, and SHALL discard any in-flight operation on reset.

Configuration
REQ-028 SHALL, when macro MULDIV_FAST_MUL_EN is defined, compute MULT and MULTU with a single-cycle combinational multiplier, going from accept directly to FIXUP, so that done is asserted in cycle N+2 and busy only in cycle N+1.
REQ-029 SHALL, when MULDIV_FAST_MUL_EN is undefined, make multiply iterative as in REQ-015, with the same latency as divide.
REQ-030 SHALL keep divide behaviour and latency identical in both configurations.

Structure
REQ-031 SHALL place op encodings, the state enumeration and the default ITER value in shared package muldiv_pkg.
REQ-032 SHALL isolate the per-cycle step datapath (partial remainder and product, shift register, adder/subtractor) in sub-module muldiv_step, instantiated once; muldiv_seq holds the FSM, counter, sign handling and result registers.

Verification
REQ-033 SHALL cover MULTU with a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE, done exactly at N+34 (N+2 with MULDIV_FAST_MUL_EN).
REQ-034 SHALL cover DIV with a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-035 SHALL cover DIVU with a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, full latency.
REQ-036 SHALL cover DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL cover cancel raised at CALC cycle 10 of a DIV after a prior MULT result of hi=1, lo=2 -> IDLE next cycle, busy=0, done never pulses, hi=1 and lo=2 kept.
REQ-038 SHALL cover start held high in the DONE cycle with new operands -> second operation begins with no IDLE cycle and the second done arrives 34 cycles after the first.
